// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//
// Shared definitions for the VGA framebuffer scan path.
//   - Standard 640x480 timing constants, used as parameter defaults by the
//     address scanner (active size and the hcnt/vcnt values of the first
//     visible pixel and line as produced by the sync/counter generator).
//   - scan_state_t: state encoding for the address scanner FSM.
// ---------------------------------------------------------------------------
package vga_pkg;

  // Visible area of the 640x480 mode.
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Counter values (from the sync generator) of the first visible pixel/line.
  localparam int H_START  = 144;
  localparam int V_START  = 35;

  // WAIT_FRAME : idle until the frame-start beat (first pixel of line 0).
  // ACTIVE     : inside a visible line, one address per clock.
  // HBLANK     : between visible lines of the current frame.
  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    HBLANK     = 2'd2
  } scan_state_t;

endpackage

// File: rtl/vga_fb_addr_scanner.sv
// ---------------------------------------------------------------------------
// vga_fb_addr_scanner
//
// Converts the hcnt/vcnt/dena stream of the VGA sync generator into linear
// framebuffer read addresses. Addresses are produced by incrementing
// counters (no multiplier): a per-line base advanced by STRIDE and a column
// address advanced once per replicated pixel group. The frame base address
// is latched only at the frame-start beat, so the producer can flip double
// buffers at any time during a frame. Pixel replication by 2^SCALE_SHIFT in
// both directions supports scaled modes; SCALE_SHIFT must be 0..3 and the
// active width/height must be divisible by the replication factor.
//
// All outputs are registered: inputs sampled at a clock edge are reflected
// on the outputs right after that same edge (one cycle of latency).
//
// Ports:
//   clk           in   pixel clock
//   reset         in   asynchronous, active-high reset
//   hcnt          in   horizontal counter from the sync generator
//   vcnt          in   vertical counter from the sync generator
//   dena          in   display enable
//   fb_base       in   frame base address, sampled at the frame-start beat
//   err_clr       in   clears sync_err (a simultaneous new error wins)
//   fb_addr       out  framebuffer read address (0 whenever not valid)
//   fb_addr_valid out  qualifies fb_addr
//   frame_start   out  pulse with the first valid address of a frame
//   line_start    out  pulse with the first valid address of every line
//   sync_err      out  sticky timing-error flag
// ---------------------------------------------------------------------------
module vga_fb_addr_scanner
  import vga_pkg::*;
#(
  parameter int CNT_W       = 10,
  parameter int ADDR_W      = 19,
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int H_START     = vga_pkg::H_START,
  parameter int V_START     = vga_pkg::V_START,
  parameter int SCALE_SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  hcnt,
  input  logic [CNT_W-1:0]  vcnt,
  input  logic              dena,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_addr_valid,
  output logic              frame_start,
  output logic              line_start,
  output logic              sync_err
);

  // Replication factor and words per source line.
  localparam int REP = 1 << SCALE_SHIFT;

  // The pixel counter must be able to hold H_ACTIVE+1 so that over-long
  // lines stay distinguishable from exact-length lines at the dena fall.
  localparam int PX_W = $clog2(H_ACTIVE + 2);
  localparam int LN_W = $clog2(V_ACTIVE + 1);

  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic [2:0]        SUB_LAST = 3'(REP - 1);
  localparam logic [CNT_W-1:0]  H_FIRST  = CNT_W'(H_START);
  localparam logic [CNT_W-1:0]  V_FIRST  = CNT_W'(V_START);
  localparam logic [PX_W-1:0]   PX_LINE  = PX_W'(H_ACTIVE);
  localparam logic [PX_W-1:0]   PX_OVER  = PX_W'(H_ACTIVE + 1);
  localparam logic [LN_W-1:0]   LN_FRAME = LN_W'(V_ACTIVE);

  scan_state_t       state, state_n;

  // line_base: address of the first word of the current source line.
  // col_addr : address to emit for the next pixel of the line.
  logic [ADDR_W-1:0] line_base, line_base_n;
  logic [ADDR_W-1:0] col_addr, col_addr_n;
  logic [2:0]        px_sub, px_sub_n;
  logic [2:0]        ln_sub, ln_sub_n;
  logic [PX_W-1:0]   px_cnt, px_cnt_n;
  logic [LN_W-1:0]   ln_cnt, ln_cnt_n;

  logic [ADDR_W-1:0] fb_addr_n;
  logic              fb_addr_valid_n;
  logic              frame_start_n;
  logic              line_start_n;
  logic              sync_err_n;

  // Emission request shared by the three places that output an address:
  // frame start, line start and a pixel inside a line.
  logic              emit;
  logic [ADDR_W-1:0] emit_addr;
  logic [2:0]        emit_sub;
  logic              frame_beat;
  logic              err_set;

  // Next-state and datapath logic. Every branch that outputs an address
  // only selects the address and the replication phase it belongs to; the
  // common tail then advances col_addr/px_sub, so the replication rule
  // lives in exactly one place. An early frame-start beat in HBLANK is
  // flagged as an error but still restarts the frame like a normal one.
  always_comb begin
    state_n         = state;
    line_base_n     = line_base;
    col_addr_n      = col_addr;
    px_sub_n        = px_sub;
    ln_sub_n        = ln_sub;
    px_cnt_n        = px_cnt;
    ln_cnt_n        = ln_cnt;
    fb_addr_n       = '0;
    fb_addr_valid_n = 1'b0;
    frame_start_n   = 1'b0;
    line_start_n    = 1'b0;
    emit            = 1'b0;
    emit_addr       = col_addr;
    emit_sub        = 3'd0;
    err_set         = 1'b0;

    frame_beat = dena && (hcnt == H_FIRST) && (vcnt == V_FIRST);

    unique case (state)
      WAIT_FRAME: begin
        if (frame_beat) begin
          state_n       = ACTIVE;
          line_base_n   = fb_base;
          ln_sub_n      = 3'd0;
          ln_cnt_n      = '0;
          px_cnt_n      = PX_W'(1);
          emit          = 1'b1;
          emit_addr     = fb_base;
          emit_sub      = 3'd0;
          frame_start_n = 1'b1;
          line_start_n  = 1'b1;
        end
      end

      ACTIVE: begin
        if (dena) begin
          // Pixels past the end of the line are swallowed; the counter
          // saturates one above the line length to mark the overrun.
          if (px_cnt < PX_LINE) begin
            emit      = 1'b1;
            emit_addr = col_addr;
            emit_sub  = px_sub;
            px_cnt_n  = px_cnt + PX_W'(1);
          end else begin
            px_cnt_n  = PX_OVER;
          end
        end else begin
          if (px_cnt != PX_LINE) begin
            err_set = 1'b1;
          end
          ln_cnt_n = ln_cnt + LN_W'(1);
          // A source line is shown REP times before moving to the next one.
          if (ln_sub == SUB_LAST) begin
            ln_sub_n    = 3'd0;
            line_base_n = line_base + STRIDE;
            col_addr_n  = line_base + STRIDE;
          end else begin
            ln_sub_n    = ln_sub + 3'd1;
            col_addr_n  = line_base;
          end
          if (ln_cnt_n == LN_FRAME) begin
            state_n = WAIT_FRAME;
          end else begin
            state_n = HBLANK;
          end
        end
      end

      HBLANK: begin
        if (dena) begin
          if (vcnt == V_FIRST) begin
            err_set = 1'b1;
          end
          state_n  = ACTIVE;
          px_cnt_n = PX_W'(1);
          emit     = 1'b1;
          emit_sub = 3'd0;
          line_start_n = 1'b1;
          if (frame_beat) begin
            line_base_n   = fb_base;
            ln_sub_n      = 3'd0;
            ln_cnt_n      = '0;
            emit_addr     = fb_base;
            frame_start_n = 1'b1;
          end else begin
            if (hcnt != H_FIRST) begin
              err_set = 1'b1;
            end
            emit_addr = col_addr;
          end
        end
      end

      default: begin
        state_n = WAIT_FRAME;
      end
    endcase

    if (emit) begin
      fb_addr_n       = emit_addr;
      fb_addr_valid_n = 1'b1;
      if (emit_sub == SUB_LAST) begin
        col_addr_n = emit_addr + ADDR_W'(1);
        px_sub_n   = 3'd0;
      end else begin
        col_addr_n = emit_addr;
        px_sub_n   = emit_sub + 3'd1;
      end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    sync_err_n = err_set | (sync_err & ~err_clr);
  end

  // State, counters and registered outputs. Reset drops the scanner back to
  // waiting for a frame-start beat, discarding any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= WAIT_FRAME;
      line_base     <= '0;
      col_addr      <= '0;
      px_sub        <= 3'd0;
      ln_sub        <= 3'd0;
      px_cnt        <= '0;
      ln_cnt        <= '0;
      fb_addr       <= '0;
      fb_addr_valid <= 1'b0;
      frame_start   <= 1'b0;
      line_start    <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      state         <= state_n;
      line_base     <= line_base_n;
      col_addr      <= col_addr_n;
      px_sub        <= px_sub_n;
      ln_sub        <= ln_sub_n;
      px_cnt        <= px_cnt_n;
      ln_cnt        <= ln_cnt_n;
      fb_addr       <= fb_addr_n;
      fb_addr_valid <= fb_addr_valid_n;
      frame_start   <= frame_start_n;
      line_start    <= line_start_n;
      sync_err      <= sync_err_n;
    end
  end

endmodule

// File: tb/tb_vga_fb_addr_scanner.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_addr_scanner
//
// Drives one hcnt/vcnt/dena stream into two scanners: dut_0 with default
// parameters and dut_1 with SCALE_SHIFT=1. For every driven cycle the
// expected outputs of both are computed from the frame base, line index and
// pixel index and queued; they are compared one cycle later. A table of
// hand-derived spot values is checked when its (frame, hcnt, vcnt) comes by.
// ---------------------------------------------------------------------------
module tb_vga_fb_addr_scanner;

  localparam int AW = 19;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          dena;
  logic [AW-1:0] fb_base;
  logic          err_clr;

  logic [AW-1:0] fb_addr_0, fb_addr_1;
  logic          fb_addr_valid_0, fb_addr_valid_1;
  logic          frame_start_0, frame_start_1;
  logic          line_start_0, line_start_1;
  logic          sync_err_0, sync_err_1;

  always #5 clk = ~clk;

  vga_fb_addr_scanner dut_0 (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt), .dena(dena),
    .fb_base(fb_base), .err_clr(err_clr),
    .fb_addr(fb_addr_0), .fb_addr_valid(fb_addr_valid_0),
    .frame_start(frame_start_0), .line_start(line_start_0),
    .sync_err(sync_err_0)
  );

  vga_fb_addr_scanner #(.SCALE_SHIFT(1)) dut_1 (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt), .dena(dena),
    .fb_base(fb_base), .err_clr(err_clr),
    .fb_addr(fb_addr_1), .fb_addr_valid(fb_addr_valid_1),
    .frame_start(frame_start_1), .line_start(line_start_1),
    .sync_err(sync_err_1)
  );

  typedef struct {
    int            frame;
    int            h;
    int            v;
    logic          valid;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic          fs;
    logic          ls;
  } exp_t;

  localparam int N_SPOT = 18;

  exp_t exp_q[$];
  exp_t spot_tbl[N_SPOT];
  bit   spot_hit[N_SPOT];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cur_frame;
  int   model_base;
  bit   clr_next;

  task automatic check_val(input string name, input int h, input int v,
                           input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s at (%0d,%0d): got 0x%0h, want 0x%0h",
               name, h, v, act, req);
    end
  endtask

  // Compares the outputs produced by the previous edge with the oldest
  // queued expectation, plus any spot-table row for the same beat.
  task automatic check_output();
    exp_t e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check_val("stream_0", e.h, e.v,
              32'({fb_addr_valid_0, fb_addr_0, frame_start_0, line_start_0}),
              32'({e.valid, e.addr0, e.fs, e.ls}));
    check_val("stream_1", e.h, e.v,
              32'({fb_addr_valid_1, fb_addr_1, frame_start_1, line_start_1}),
              32'({e.valid, e.addr1, e.fs, e.ls}));
    for (int i = 0; i < N_SPOT; i++) begin
      if (spot_tbl[i].frame == e.frame && spot_tbl[i].h == e.h &&
          spot_tbl[i].v == e.v) begin
        spot_hit[i] = 1'b1;
        check_val($sformatf("spot%0d_0", i), e.h, e.v,
                  32'({fb_addr_valid_0, fb_addr_0, frame_start_0, line_start_0}),
                  32'({spot_tbl[i].valid, spot_tbl[i].addr0, spot_tbl[i].fs,
                       spot_tbl[i].ls}));
        check_val($sformatf("spot%0d_1", i), e.h, e.v,
                  32'({fb_addr_valid_1, fb_addr_1, frame_start_1, line_start_1}),
                  32'({spot_tbl[i].valid, spot_tbl[i].addr1, spot_tbl[i].fs,
                       spot_tbl[i].ls}));
      end
    end
  endtask

  // One clock of stimulus. in_frame says whether this beat belongs to a frame
  // the scanners should be emitting; line_idx/px_idx locate it in the image.
  task automatic apply_stimulus(input int h, input int v, input bit de,
                                input bit in_frame, input int line_idx,
                                input int px_idx);
    exp_t e;
    @(negedge clk);
    check_output();
    hcnt     = CW'(h);
    vcnt     = CW'(v);
    dena     = de;
    err_clr  = clr_next;
    clr_next = 1'b0;
    e = '{frame: cur_frame, h: h, v: v, valid: 1'b0, addr0: '0, addr1: '0,
          fs: 1'b0, ls: 1'b0};
    if (in_frame && de && px_idx < 640) begin
      e.valid = 1'b1;
      e.addr0 = AW'(model_base + line_idx * 640 + px_idx);
      e.addr1 = AW'(model_base + (line_idx / 2) * 320 + px_idx / 2);
      e.fs    = (line_idx == 0 && px_idx == 0);
      e.ls    = (px_idx == 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic run_line(input int v, input int line_idx, input int npix,
                          input int nblank, input bit in_frame);
    for (int p = 0; p < npix; p++)
      apply_stimulus(144 + p, v, 1'b1, in_frame, line_idx, p);
    for (int b = 0; b < nblank; b++)
      apply_stimulus(144 + npix + b, v, 1'b0, in_frame, line_idx, 0);
  endtask

  task automatic check_err(input logic want, input string name);
    check_val({name, "_0"}, int'(hcnt), int'(vcnt), 32'(sync_err_0), 32'(want));
    check_val({name, "_1"}, int'(hcnt), int'(vcnt), 32'(sync_err_1), 32'(want));
  endtask

  task automatic check_zero(input string name);
    check_val({name, "_0"}, int'(hcnt), int'(vcnt),
              32'({fb_addr_valid_0, fb_addr_0, frame_start_0, line_start_0,
                   sync_err_0}), 32'(0));
    check_val({name, "_1"}, int'(hcnt), int'(vcnt),
              32'({fb_addr_valid_1, fb_addr_1, frame_start_1, line_start_1,
                   sync_err_1}), 32'(0));
  endtask

  initial begin
    // frame, h, v, valid, addr (default), addr (x2 scaled), frame_start, line_start
    spot_tbl[0]  = '{0, 144,  35, 1'b1, 19'd0,      19'd0,      1'b1, 1'b1};
    spot_tbl[1]  = '{0, 145,  35, 1'b1, 19'd1,      19'd0,      1'b0, 1'b0};
    spot_tbl[2]  = '{0, 146,  35, 1'b1, 19'd2,      19'd1,      1'b0, 1'b0};
    spot_tbl[3]  = '{0, 783,  35, 1'b1, 19'd639,    19'd319,    1'b0, 1'b0};
    spot_tbl[4]  = '{0, 144,  36, 1'b1, 19'd640,    19'd0,      1'b0, 1'b1};
    spot_tbl[5]  = '{0, 783,  36, 1'b1, 19'd1279,   19'd319,    1'b0, 1'b0};
    spot_tbl[6]  = '{0, 144,  37, 1'b1, 19'd1280,   19'd320,    1'b0, 1'b1};
    spot_tbl[7]  = '{0, 783, 514, 1'b1, 19'd307199, 19'd76799,  1'b0, 1'b0};
    spot_tbl[8]  = '{1, 144,  35, 1'b1, 19'h20000,  19'h20000,  1'b1, 1'b1};
    spot_tbl[9]  = '{1, 144, 100, 1'b1, 19'd172672, 19'd141312, 1'b0, 1'b1};
    spot_tbl[10] = '{2, 144,  35, 1'b1, 19'h40000,  19'h40000,  1'b1, 1'b1};
    spot_tbl[11] = '{2, 783,  36, 1'b1, 19'd263423, 19'd262463, 1'b0, 1'b0};
    spot_tbl[12] = '{2, 784,  36, 1'b0, 19'd0,      19'd0,      1'b0, 1'b0};
    spot_tbl[13] = '{2, 144,  37, 1'b1, 19'd263424, 19'd262464, 1'b0, 1'b1};
    spot_tbl[14] = '{3, 144,  35, 1'b1, 19'h7FF00,  19'h7FF00,  1'b1, 1'b1};
    spot_tbl[15] = '{3, 400,  35, 1'b1, 19'd0,      19'h7FF80,  1'b0, 1'b0};
    spot_tbl[16] = '{3, 144,  36, 1'b1, 19'd384,    19'h7FF00,  1'b0, 1'b1};
    spot_tbl[17] = '{4, 144,  35, 1'b1, 19'h00100,  19'h00100,  1'b1, 1'b1};

    reset      = 1'b1;
    hcnt       = '0;
    vcnt       = '0;
    dena       = 1'b0;
    fb_base    = '0;
    err_clr    = 1'b0;
    clr_next   = 1'b0;
    cur_frame  = -1;
    model_base = 0;

    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;

    // Idle, then a display-enable burst that is not a frame-start beat.
    for (int b = 0; b < 3; b++) apply_stimulus(10 + b, 20, 1'b0, 1'b0, 0, 0);
    run_line(40, 0, 4, 2, 1'b0);

    // Frame 0: base 0, full first/last lines, 1-pixel lines in between.
    $display("[TB] frame 0: base 0x00000");
    cur_frame = 0; model_base = 0; fb_base = '0;
    run_line(35, 0, 640, 2, 1'b1);
    run_line(36, 1, 640, 2, 1'b1);
    run_line(37, 2, 640, 2, 1'b1);
    check_err(1'b0, "err_clean_lines");
    for (int l = 3; l < 479; l++) begin
      run_line(35 + l, l, 1, 2, 1'b1);
      if (l == 3) check_err(1'b1, "err_short_line");
    end
    run_line(514, 479, 640, 2, 1'b1);
    for (int b = 0; b < 3; b++) apply_stimulus(800 + b, 520, 1'b0, 1'b0, 0, 0);

    // Frame 1: base 0x20000, fb_base changed mid-frame.
    $display("[TB] frame 1: base 0x20000, fb_base moved at line 100");
    cur_frame = 1; model_base = 'h20000; fb_base = 19'h20000;
    for (int l = 0; l < 480; l++) begin
      if (l == 65) fb_base = 19'h40000;
      run_line(35 + l, l, 1, 2, 1'b1);
    end
    clr_next = 1'b1;
    apply_stimulus(800, 520, 1'b0, 1'b0, 0, 0);
    apply_stimulus(801, 520, 1'b0, 1'b0, 0, 0);
    check_err(1'b0, "err_clr_idle");

    // Frame 2: picks up the new base; long line, set-wins, then reset.
    $display("[TB] frame 2: base 0x40000");
    cur_frame = 2; model_base = 'h40000;
    run_line(35, 0, 640, 2, 1'b1);
    run_line(36, 1, 642, 2, 1'b1);
    check_err(1'b1, "err_long_line");
    apply_stimulus(144, 37, 1'b1, 1'b1, 2, 0);
    clr_next = 1'b1;
    apply_stimulus(145, 37, 1'b0, 1'b1, 2, 0);
    apply_stimulus(146, 37, 1'b0, 1'b1, 2, 0);
    check_err(1'b1, "err_set_wins");
    clr_next = 1'b1;
    apply_stimulus(147, 37, 1'b0, 1'b1, 2, 0);
    apply_stimulus(148, 37, 1'b0, 1'b1, 2, 0);
    check_err(1'b0, "err_clr_hblank");
    for (int l = 3; l < 165; l++) run_line(35 + l, l, 1, 2, 1'b1);
    for (int p = 0; p < 256; p++) apply_stimulus(144 + p, 200, 1'b1, 1'b1, 165, p);

    @(negedge clk);
    check_output();
    hcnt = CW'(400); vcnt = CW'(200); dena = 1'b1;
    reset = 1'b1;
    #1;
    check_zero("reset_mid_frame");
    exp_q.delete();
    for (int i = 0; i < 3; i++) apply_stimulus(401 + i, 200, 1'b1, 1'b0, 0, 0);
    reset = 1'b0;
    for (int h = 404; h < 784; h++) apply_stimulus(h, 200, 1'b1, 1'b0, 0, 0);
    apply_stimulus(784, 200, 1'b0, 1'b0, 0, 0);
    for (int v = 201; v < 211; v++) run_line(v, 0, 8, 2, 1'b0);

    // Frame 3: base near the top of the address space to exercise the wrap.
    $display("[TB] frame 3: base 0x7FF00");
    fb_base = 19'h7FF00;
    cur_frame = 3; model_base = 'h7FF00;
    run_line(35, 0, 640, 2, 1'b1);
    run_line(36, 1, 640, 2, 1'b1);
    check_err(1'b0, "err_after_reset");

    // Early frame-start beat during HBLANK restarts with the new base.
    fb_base = 19'h00100;
    cur_frame = 4; model_base = 'h100;
    apply_stimulus(144, 35, 1'b1, 1'b1, 0, 0);
    apply_stimulus(145, 35, 1'b1, 1'b1, 0, 1);
    check_err(1'b1, "err_early_frame");
    for (int p = 2; p < 640; p++) apply_stimulus(144 + p, 35, 1'b1, 1'b1, 0, p);
    apply_stimulus(784, 35, 1'b0, 1'b1, 0, 0);
    apply_stimulus(785, 35, 1'b0, 1'b1, 0, 0);
    run_line(36, 1, 4, 2, 1'b1);
    apply_stimulus(790, 36, 1'b0, 1'b0, 0, 0);
    apply_stimulus(791, 36, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < N_SPOT; i++)
      check_val($sformatf("spot%0d_seen", i), spot_tbl[i].h, spot_tbl[i].v,
                32'(spot_hit[i]), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
